// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encodings,
// port indices and the alignment helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  function automatic logic misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational grant selection between the CPU and loader/debug ports.
// DMEM_ARB_RR_EN selects round-robin on contention; otherwise the CPU always wins.
module dmem_arb_grant
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

`ifndef DMEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  // A lone requester always wins; contention is the only mode-dependent case.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11: begin
`ifdef DMEM_ARB_RR_EN
        if (last_grant_i == PORT_CPU) begin
          grant_o = 2'b10;
        end else begin
          grant_o = 2'b01;
        end
`else
        grant_o = 2'b01;
`endif
      end
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one transaction at a time through IDLE/ACCESS/RESP.
// Build with DMEM_ARB_RR_EN for round-robin arbitration (default: fixed CPU priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e            state_q;
  logic              port_q;
  logic              write_q;
  logic              err_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_write_data_q;
  logic [1:0]        rsp_valid_q;
  logic [1:0]        rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q [2];

  logic [1:0]        grant_s;
  logic              last_grant_s;
  logic              accept_s;
  logic              acc_port_s;
  logic              acc_write_s;
  logic              acc_err_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [DATA_W-1:0] acc_wdata_s;

`ifdef DMEM_ARB_RR_EN
  logic last_grant_q;
  assign last_grant_s = last_grant_q;
`else
  assign last_grant_s = PORT_AUX;
`endif

  dmem_arb_grant u_grant (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_s),
    .grant_o      (grant_s)
  );

  assign accept_s    = (state_q == IDLE) && (grant_s != 2'b00);
  assign acc_port_s  = grant_s[PORT_AUX];
  assign acc_write_s = acc_port_s ? req1_write : req0_write;
  assign acc_addr_s  = acc_port_s ? req1_addr  : req0_addr;
  assign acc_wdata_s = acc_port_s ? req1_wdata : req0_wdata;
  assign acc_err_s   = misaligned(acc_addr_s[1:0]);

  // Ready is held low during reset so nothing appears accepted while the block is cleared.
  assign req0_ready = ~rst & (state_q == IDLE) & grant_s[PORT_CPU];
  assign req1_ready = ~rst & (state_q == IDLE) & grant_s[PORT_AUX];

  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign rsp0_valid     = rsp_valid_q[PORT_CPU];
  assign rsp1_valid     = rsp_valid_q[PORT_AUX];
  assign rsp0_err       = rsp_err_q[PORT_CPU];
  assign rsp1_err       = rsp_err_q[PORT_AUX];
  assign rsp0_rdata     = rsp_rdata_q[PORT_CPU];
  assign rsp1_rdata     = rsp_rdata_q[PORT_AUX];

  // Transaction FSM; memory strobes and responses are single-cycle registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      port_q           <= 1'b0;
      write_q          <= 1'b0;
      err_q            <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      rsp_valid_q      <= 2'b00;
      rsp_err_q        <= 2'b00;
      rsp_rdata_q[0]   <= '0;
      rsp_rdata_q[1]   <= '0;
`ifdef DMEM_ARB_RR_EN
      last_grant_q     <= PORT_AUX;
`endif
    end else begin
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      rsp_valid_q      <= 2'b00;
      rsp_err_q        <= 2'b00;
      rsp_rdata_q[0]   <= '0;
      rsp_rdata_q[1]   <= '0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q          <= ACCESS;
            port_q           <= acc_port_s;
            write_q          <= acc_write_s;
            err_q            <= acc_err_s;
            mem_address_q    <= acc_addr_s;
            mem_write_data_q <= acc_wdata_s;
            mem_read_q       <= ~acc_write_s & ~acc_err_s;
            mem_write_q      <= acc_write_s & ~acc_err_s;
`ifdef DMEM_ARB_RR_EN
            last_grant_q     <= acc_port_s;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q             <= RESP;
          rsp_valid_q[port_q] <= 1'b1;
          rsp_err_q[port_q]   <= err_q;
          if (!write_q && !err_q) begin
            rsp_rdata_q[port_q] <= mem_read_data;
          end else begin
            rsp_rdata_q[port_q] <= '0;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of requests and memory port.
REQ-002 Parameter DATA_W, default 32, word width of write/read data.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 reqN_valid  in  1  port N (N=0,1) request present; port 0 = CPU load/store, port 1 = loader/debug.
REQ-006 reqN_write  in  1  1 = store, 0 = load.
REQ-007 reqN_addr  in  ADDR_W  byte address.
REQ-008 reqN_wdata  in  DATA_W  store data.
REQ-009 reqN_ready  out  1  request accepted this cycle.
REQ-010 rspN_valid  out  1  one-cycle response pulse.
REQ-011 rspN_rdata  out  DATA_W  load data; 0 for stores and errors.
REQ-012 rspN_err  out  1  misaligned-address error, valid with rspN_valid.
REQ-013 mem_read, mem_write  out  1 each  strobes to the data memory.
REQ-014 mem_address  out  ADDR_W; mem_write_data  out  DATA_W; mem_read_data  in  DATA_W (combinational read, write commits on rising edge).

Function
REQ-015 FSM states IDLE, ACCESS, RESP; IDLE -> ACCESS on accept; ACCESS -> RESP unconditionally; RESP -> IDLE unconditionally.
REQ-016 reqN_ready SHALL be combinational, high only in IDLE and only for the granted port with reqN_valid high; accept = valid & ready at a rising edge.
REQ-017 On accept, latch port index, write flag, addr, wdata; requester may change inputs afterwards.
REQ-018 In ACCESS, drive mem_address/mem_write_data from latches and assert exactly one of mem_read/mem_write for exactly one cycle; all mem outputs 0 in other states.
REQ-019 Load data SHALL be captured from mem_read_data at the edge ending ACCESS.
REQ-020 In RESP, assert rspN_valid for the latched port only, for exactly one cycle; response at cycle accept+2; max one accept per 3 cycles.
REQ-021 addr[1:0] != 0: no memory strobe in ACCESS; response with rspN_err=1, rspN_rdata=0.
REQ-022 Stores respond with rspN_rdata=0, rspN_err=0.
REQ-023 Requests arriving outside IDLE SHALL wait (ready low); no request is dropped or duplicated while valid is held.
REQ-024 Single valid requester in IDLE is granted regardless of arbitration mode.

Reset
REQ-025 rst asserted: state=IDLE, all outputs 0, latches 0, last_grant=1, effective immediately (asynchronous).
REQ-026 rst during ACCESS or RESP aborts the transaction: no response issued, no memory write at the following edge.
REQ-027 First cycle after rst deassertion accepts requests normally.

Configuration
REQ-028 Macro DMEM_ARB_RR_EN defined: round-robin; on simultaneous valid, grant port != last_grant; last_grant updates on each accept.
REQ-029 Macro undefined: fixed priority, port 0 always wins; last_grant register not implemented.

Structure
REQ-030 Shared package dmem_arb_pkg holds state encodings (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10) and port-index constants PORT_CPU=0, PORT_AUX=1.
REQ-031 Grant selection in sub-module dmem_arb_grant (combinational, inputs valid[1:0], last_grant; output one-hot grant).

Verification
REQ-032 Memory word 0x100=4; port0 load 0x100 -> ready in accept cycle, mem_read high one cycle with mem_address=0x100, rsp0_valid at accept+2, rsp0_rdata=4, err=0.
REQ-033 Port1 store 0x104 data 7, then port0 load 0x104 -> one mem_write cycle with data 7; rsp1_rdata=0; later rsp0_rdata=7.
REQ-034 Both ports valid continuously for 12 cycles -> RR build grants 0,1,0,1 (4 accepts); fixed build grants port0 4 times, port1 never.
REQ-035 Port0 load 0x102 -> no mem strobe, rsp0_err=1, rsp0_rdata=0 at accept+2.
REQ-036 Port1 store 0x108 data 9, rst pulsed during ACCESS -> outputs 0 immediately, no rsp1_valid, word 0x108 unchanged; next port0 load served with standard latency.
REQ-037 Port1 valid held while port0 transaction in flight -> req1_ready low until IDLE, then exactly one accept for that request.
